// File: rtl/pingpong_pkg.sv
// Shared bank state encodings and default geometry for the ping-pong buffer.
// Latency: n/a. Backpressure: n/a.
// Imported by the buffer top.
package pingpong_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int AW_DEF     = 10;

    typedef enum logic [2:0] {
        ST_REQ     = 3'b001,
        ST_FILLING = 3'b010,
        ST_FULL    = 3'b011,
        ST_IN_USE  = 3'b100
    } bank_state_e;

    // A bank accepts prefetch beats only until it has been sealed as FULL.
    function automatic logic is_writable(input bank_state_e s);
        return (s == ST_REQ) || (s == ST_FILLING);
    endfunction

endpackage

// File: rtl/pingpong_buffer_if.sv
// Prefetcher write, bank-state and consumer read signals of the ping-pong buffer.
// Latency: wiring only. Backpressure: the prefetcher is steered by the bank state codes.
// Optional PINGPONG_STATS_EN adds the starve_cnt/drop_cnt statistics outputs.
interface pingpong_buffer_if #(
    parameter int DATA_W = 64,
    parameter int AW     = 10
) ();

    logic              prefetch_select;
    logic              prefetch_enable;
    logic              prefetch_write;
    logic              prefetch_finish;
    logic [DATA_W-1:0] data_out;
    logic [31:0]       data_out_address;
    logic [2:0]        buffer0_state;
    logic [2:0]        buffer1_state;
    logic              use_select;
    logic              cons_valid;
    logic              cons_rd_en;
    logic [AW-1:0]     cons_rd_addr;
    logic [DATA_W-1:0] cons_rd_data;
    logic              cons_release;
`ifdef PINGPONG_STATS_EN
    logic [31:0]       starve_cnt;
    logic [15:0]       drop_cnt;
`endif

    modport master (
        output prefetch_select, prefetch_enable, prefetch_write, prefetch_finish,
        output data_out, data_out_address,
        output cons_rd_en, cons_rd_addr, cons_release,
        input  buffer0_state, buffer1_state, use_select, cons_valid, cons_rd_data
`ifdef PINGPONG_STATS_EN
        , input starve_cnt, drop_cnt
`endif
    );

    modport slave (
        input  prefetch_select, prefetch_enable, prefetch_write, prefetch_finish,
        input  data_out, data_out_address,
        input  cons_rd_en, cons_rd_addr, cons_release,
        output buffer0_state, buffer1_state, use_select, cons_valid, cons_rd_data
`ifdef PINGPONG_STATS_EN
        , output starve_cnt, drop_cnt
`endif
    );

endinterface

// File: rtl/pingpong_bank.sv
// One bank of the ping-pong buffer: simple dual-port RAM, one write port, one registered read port.
// Latency: read data valid 1 cycle after i_rd_en. Backpressure: none, always accepts.
// Read register holds its value when i_rd_en is low.
module pingpong_bank #(
    parameter int DATA_W = 64,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [2**AW];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer between DMA prefetcher and consumer; per-bank FSMs, strict 0/1 handoff.
// Latency: bank promotion 1 cycle after FULL, read data 1 cycle. Backpressure: writes to FULL/IN_USE banks dropped.
// PINGPONG_STATS_EN adds starve_cnt/drop_cnt counters.
module pingpong_buffer
    import pingpong_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic clk,
    input  logic rst,
    pingpong_buffer_if.slave bus
);

    bank_state_e       r_state     [2];
    bank_state_e       w_state_nxt [2];
    logic              r_use_sel;
    logic              w_use_sel_nxt;
    logic              r_next_bank;
    logic              w_next_bank_nxt;
    logic              r_finish_prev;
    logic              r_rd_sel;
    logic              w_any_in_use;
    logic              w_finish_rise;
    logic              w_cons_rd;
    logic [1:0]        w_wr_en;
    logic [1:0]        w_rd_en;
    logic [AW-1:0]     w_wr_addr;
    logic [DATA_W-1:0] w_rd_dat [2];
    logic              w_unused_addr;

    assign w_any_in_use  = (r_state[0] == ST_IN_USE) || (r_state[1] == ST_IN_USE);
    assign w_finish_rise = bus.prefetch_finish && !r_finish_prev;
    assign w_cons_rd     = bus.cons_rd_en && w_any_in_use;
    assign w_wr_addr     = bus.data_out_address[AW:1];
    assign w_unused_addr = ^{bus.data_out_address[31:AW+1], bus.data_out_address[0]};

    // Promotion looks only at registered states, so a release and the next promotion are a cycle apart.
    always_comb begin
        w_state_nxt     = r_state;
        w_use_sel_nxt   = r_use_sel;
        w_next_bank_nxt = r_next_bank;
        w_wr_en         = '0;
        w_rd_en         = '0;
        for (int b = 0; b < 2; b++) begin
            w_wr_en[b] = bus.prefetch_write && (bus.prefetch_select == b[0]) && is_writable(r_state[b]);
            w_rd_en[b] = w_cons_rd && (r_use_sel == b[0]);
            case (r_state[b])
                ST_REQ: begin
                    if (bus.prefetch_enable && (bus.prefetch_select == b[0])) begin
                        w_state_nxt[b] = ST_FILLING;
                    end
                end
                ST_FILLING: begin
                    if (w_finish_rise && (bus.prefetch_select == b[0])) begin
                        w_state_nxt[b] = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if ((r_next_bank == b[0]) && !w_any_in_use) begin
                        w_state_nxt[b]  = ST_IN_USE;
                        w_use_sel_nxt   = b[0];
                        w_next_bank_nxt = ~b[0];
                    end
                end
                ST_IN_USE: begin
                    if (bus.cons_release) begin
                        w_state_nxt[b] = ST_REQ;
                    end
                end
                default: w_state_nxt[b] = ST_REQ;
            endcase
        end
    end

    // Finish is treated as high out of reset so an idle prefetcher does not fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0]    <= ST_REQ;
            r_state[1]    <= ST_REQ;
            r_use_sel     <= 1'b0;
            r_next_bank   <= 1'b0;
            r_finish_prev <= 1'b1;
            r_rd_sel      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_use_sel     <= w_use_sel_nxt;
            r_next_bank   <= w_next_bank_nxt;
            r_finish_prev <= bus.prefetch_finish;
            if (w_cons_rd) begin
                r_rd_sel <= r_use_sel;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pingpong_bank #(
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_addr (w_wr_addr),
            .i_wr_dat  (bus.data_out),
            .i_rd_en   (w_rd_en[g]),
            .i_rd_addr (bus.cons_rd_addr),
            .o_rd_dat  (w_rd_dat[g])
        );
    end

    assign bus.buffer0_state = r_state[0];
    assign bus.buffer1_state = r_state[1];
    assign bus.use_select    = r_use_sel;
    assign bus.cons_valid    = w_any_in_use;
    assign bus.cons_rd_data  = r_rd_sel ? w_rd_dat[1] : w_rd_dat[0];

`ifdef PINGPONG_STATS_EN
    logic [31:0] r_starve_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_starve;
    logic        w_drop;

    assign w_starve = !w_any_in_use && (r_state[0] != ST_FULL) && (r_state[1] != ST_FULL);
    assign w_drop   = bus.prefetch_write && !is_writable(r_state[bus.prefetch_select]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_starve) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.starve_cnt = r_starve_cnt;
    assign bus.drop_cnt   = r_drop_cnt;
`endif

endmodule
